// File: rtl/mawg_capture.sv
// mawg_capture: waveform capture engine.
// Writes a qualified sample stream into a single-port wave RAM. The writes
// are steered by a segment table whose entries use the same
// {decim, length, start} layout as the mawg playback engine.
//
// State table:
//   S_IDLE    | waiting for i_kick; table writes still accepted
//   S_LOAD    | one-cycle fetch of the current entry into working registers
//   S_CAPTURE | writing samples of the current entry, with decimation
//
// Ports:
//   i_clk, i_reset             clock, async active-low reset
//   i_ctrl_addr/data/we        segment table write port
//   i_kick, i_ctrl_length      start a run over entries 0..ctrl_length-1
//   i_force_stop               abort the run, no done pulse
//   o_busy, o_done             run in progress / normal completion pulse
//   i_in_data, i_in_valid      sample stream, no backpressure
//   o_wave_addr/din/we         registered RAM write port
//   o_dropped                  saturating count of valid samples lost while busy
module mawg_capture #(
  parameter int CTRL_DEPTH = 4,
  parameter int WAVE_DEPTH = 16,
  parameter int WAVE_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [CTRL_DEPTH-1:0]   i_ctrl_addr,
  input  logic [2*WAVE_DEPTH+15:0] i_ctrl_data,
  input  logic                    i_ctrl_we,
  input  logic                    i_kick,
  input  logic [CTRL_DEPTH-1:0]   i_ctrl_length,
  input  logic                    i_force_stop,
  output logic                    o_busy,
  output logic                    o_done,
  input  logic [WAVE_WIDTH-1:0]   i_in_data,
  input  logic                    i_in_valid,
  output logic [WAVE_DEPTH-1:0]   o_wave_addr,
  output logic [WAVE_WIDTH-1:0]   o_wave_din,
  output logic                    o_wave_we,
  output logic [15:0]             o_dropped
);

  localparam int CW = 2*WAVE_DEPTH+16;
  localparam int NE = 2**CTRL_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_table [NE];
  logic [CTRL_DEPTH-1:0] r_idx;
  logic [CTRL_DEPTH-1:0] r_len;
  logic [WAVE_DEPTH-1:0] r_addr;
  logic [WAVE_DEPTH-1:0] r_remain;
  logic [15:0]           r_decim;
  logic [15:0]           r_dcnt;

  logic [CW-1:0]         w_entry;
  logic [WAVE_DEPTH-1:0] w_start;
  logic [WAVE_DEPTH-1:0] w_length;
  logic [15:0]           w_decim;
  logic [CTRL_DEPTH-1:0] w_idx_next;
  logic                  w_last;
  logic [15:0]           w_dcnt_next;
  logic [15:0]           w_drop_inc;

  assign w_entry    = r_table[r_idx];
  assign w_start    = w_entry[WAVE_DEPTH-1:0];
  assign w_length   = w_entry[2*WAVE_DEPTH-1:WAVE_DEPTH];
  assign w_decim    = w_entry[CW-1:2*WAVE_DEPTH];
  assign w_idx_next = r_idx + CTRL_DEPTH'(1);
  assign w_last     = (w_idx_next == r_len);

  // decim of 0 or 1 keeps the counter parked at 0 so every sample is written
  assign w_dcnt_next = ((r_decim <= 16'd1) || (r_dcnt == r_decim - 16'd1)) ?
                       16'd0 : r_dcnt + 16'd1;
  assign w_drop_inc  = (o_dropped == 16'hFFFF) ? o_dropped : o_dropped + 16'd1;

  // Table is writable in every state; LOAD sees the value present before the edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NE; i++) r_table[i] <= '0;
    end else if (i_ctrl_we) begin
      r_table[i_ctrl_addr] <= i_ctrl_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_remain    <= '0;
      r_decim     <= '0;
      r_dcnt      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_wave_we   <= 1'b0;
      o_wave_addr <= '0;
      o_wave_din  <= '0;
      o_dropped   <= '0;
    end else begin
      o_done    <= 1'b0;
      o_wave_we <= 1'b0;
      if (i_force_stop) begin
        r_state <= S_IDLE;
        o_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_kick) begin
              r_len     <= i_ctrl_length;
              r_idx     <= '0;
              o_dropped <= '0;
              if (i_ctrl_length == '0) begin
                o_done <= 1'b1;
              end else begin
                r_state <= S_LOAD;
                o_busy  <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            if (i_in_valid) o_dropped <= w_drop_inc;
            if (w_length == '0) begin
              // empty entry: skip it without leaving LOAD
              r_idx <= w_idx_next;
              if (w_last) begin
                r_state <= S_IDLE;
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
              end
            end else begin
              r_addr   <= w_start;
              r_remain <= w_length;
              r_decim  <= w_decim;
              r_dcnt   <= '0;
              r_state  <= S_CAPTURE;
            end
          end

          S_CAPTURE: begin
            if (i_in_valid) begin
              r_dcnt <= w_dcnt_next;
              if (r_dcnt == 16'd0) begin
                o_wave_we   <= 1'b1;
                o_wave_addr <= r_addr;
                o_wave_din  <= i_in_data;
                r_addr      <= r_addr + WAVE_DEPTH'(1);
                r_remain    <= r_remain - WAVE_DEPTH'(1);
                if (r_remain == WAVE_DEPTH'(1)) begin
                  r_idx <= w_idx_next;
                  if (w_last) begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                  end else begin
                    r_state <= S_LOAD;
                  end
                end
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mawg_capture.sv
module tb_mawg_capture;
  localparam int W = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ctrl_addr;
  logic [47:0] ctrl_data;
  logic        ctrl_we;
  logic        kick;
  logic [3:0]  ctrl_length;
  logic        force_stop;
  logic        busy;
  logic        done;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] wave_addr;
  logic [15:0] wave_din;
  logic        wave_we;
  logic [15:0] dropped;

  always #5 clk = ~clk;

  mawg_capture dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_ctrl_addr(ctrl_addr), .i_ctrl_data(ctrl_data), .i_ctrl_we(ctrl_we),
    .i_kick(kick), .i_ctrl_length(ctrl_length), .i_force_stop(force_stop),
    .o_busy(busy), .o_done(done),
    .i_in_data(in_data), .i_in_valid(in_valid),
    .o_wave_addr(wave_addr), .o_wave_din(wave_din), .o_wave_we(wave_we),
    .o_dropped(dropped)
  );

  int checks = 0;
  int errors = 0;

  // reference table and per-run expected timeline, indexed by edge number
  // relative to the kick edge (r = 0)
  logic [47:0] m_tab [16];
  bit          ev [W];
  logic [15:0] ed [W];
  bit          e_busy [W];
  bit          e_done [W];
  bit          e_we [W];
  logic [15:0] e_addr [W];
  logic [15:0] e_din [W];
  logic [15:0] e_drop [W];

  int          cur_r = 0;
  bit          cmp_en = 1'b0;
  int          done_cnt = 0;
  logic [15:0] obs_addr [$];
  logic [15:0] obs_din [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk($sformatf("busy@%0d", cur_r), 32'(busy), 32'(e_busy[cur_r]));
      chk($sformatf("done@%0d", cur_r), 32'(done), 32'(e_done[cur_r]));
      chk($sformatf("we@%0d", cur_r), 32'(wave_we), 32'(e_we[cur_r]));
      chk($sformatf("dropped@%0d", cur_r), 32'(dropped), 32'(e_drop[cur_r]));
      if (e_we[cur_r]) begin
        chk($sformatf("addr@%0d", cur_r), 32'(wave_addr), 32'(e_addr[cur_r]));
        chk($sformatf("din@%0d", cur_r), 32'(wave_din), 32'(e_din[cur_r]));
      end
      if (wave_we) begin
        obs_addr.push_back(wave_addr);
        obs_din.push_back(wave_din);
      end
      if (done) done_cnt++;
    end
  end

  // Walk the entries in order: one LOAD edge per entry, then consume valid
  // samples until the entry's length is written. force_stop truncates.
  task automatic run_model(input int len, input int stop_r);
    bit drop_at [W];
    int end_r = W;
    bit fin = 0;
    int c, dec, ln, a, rem, k, cnt;
    for (int r = 0; r < W; r++) begin
      drop_at[r] = 0; e_we[r] = 0; e_addr[r] = 0; e_din[r] = 0;
      e_busy[r] = 0; e_done[r] = 0;
    end
    if (len == 0) begin
      fin = 1; end_r = 0;
    end else begin
      c = 1;
      for (int i = 0; i < len && c < W; i++) begin
        dec = int'(m_tab[i][47:32]);
        ln  = int'(m_tab[i][31:16]);
        a   = int'(m_tab[i][15:0]);
        if (ev[c]) drop_at[c] = 1;
        if (ln == 0) begin
          if (i == len - 1) begin fin = 1; end_r = c; end
          c++;
          continue;
        end
        c++;
        rem = ln; k = 0;
        while (rem > 0 && c < W) begin
          if (ev[c]) begin
            if (dec <= 1 || (k % dec) == 0) begin
              e_we[c] = 1; e_addr[c] = 16'(a); e_din[c] = ed[c];
              a = (a + 1) % 65536; rem--;
            end
            k++;
          end
          if (rem == 0 && i == len - 1) begin fin = 1; end_r = c; end
          c++;
        end
      end
    end
    for (int r = 0; r < W; r++)
      if (r >= stop_r) begin e_we[r] = 0; drop_at[r] = 0; end
    if (stop_r <= end_r) begin fin = 0; end_r = stop_r; end
    cnt = 0;
    for (int r = 0; r < W; r++) begin
      e_busy[r] = (r < end_r);
      e_done[r] = fin && (r == end_r);
      if (drop_at[r]) cnt++;
      e_drop[r] = 16'(cnt);
    end
  endtask

  task automatic wr(input int idx, input int dec, input int ln, input int st);
    ctrl_addr = 4'(idx);
    ctrl_data = {16'(dec), 16'(ln), 16'(st)};
    ctrl_we   = 1'b1;
    @(posedge clk); #2;
    ctrl_we   = 1'b0;
    m_tab[idx] = {16'(dec), 16'(ln), 16'(st)};
  endtask

  // valid samples run on consecutive edges starting at r = 2
  task automatic do_run(input int len, input int nval, input int dbase,
                        input int stop_r, input int k2_r);
    for (int r = 0; r < W; r++) begin
      ev[r] = (r >= 2) && (r < 2 + nval);
      ed[r] = ev[r] ? 16'(dbase + r - 2) : 16'h0;
    end
    run_model(len, stop_r);
    obs_addr.delete(); obs_din.delete(); done_cnt = 0;
    @(posedge clk); #2;
    for (int r = 0; r < W; r++) begin
      kick        = (r == 0) || (r == k2_r);
      ctrl_length = (r == 0) ? 4'(len) : 4'd1;
      in_valid    = ev[r];
      in_data     = ed[r];
      force_stop  = (r == stop_r);
      @(posedge clk);
      cur_r = r; cmp_en = 1'b1;
      #2;
    end
    kick = 0; in_valid = 0; in_data = 0; force_stop = 0; ctrl_length = 0;
    @(negedge clk); #1;
    cmp_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_we"}, 32'(wave_we), 32'd0);
    chk({tag, "_addr"}, 32'(wave_addr), 32'd0);
    chk({tag, "_din"}, 32'(wave_din), 32'd0);
    chk({tag, "_dropped"}, 32'(dropped), 32'd0);
  endtask

  initial begin
    rst_n = 0; ctrl_addr = 0; ctrl_data = 0; ctrl_we = 0; kick = 0;
    ctrl_length = 0; force_stop = 0; in_data = 0; in_valid = 0;
    for (int i = 0; i < 16; i++) m_tab[i] = '0;
    #12;
    chk_reset_vals("por");
    rst_n = 1;
    @(posedge clk); #2;

    // 1: plain capture of 10 samples
    wr(0, 1, 10, 0);
    do_run(1, 12, 16'h0100, W, -1);
    chk("t1_nwrites", 32'(obs_addr.size()), 32'd10);
    if (obs_addr.size() == 10) begin
      chk("t1_addr0", 32'(obs_addr[0]), 32'h0);
      chk("t1_addr9", 32'(obs_addr[9]), 32'h9);
      chk("t1_din9", 32'(obs_din[9]), 32'h0109);
    end
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_dropped", 32'(dropped), 32'd0);

    // 2: decimation by 3
    wr(0, 3, 4, 16'h0020);
    do_run(1, 12, 0, W, -1);
    chk("t2_nwrites", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("t2_din1", 32'(obs_din[1]), 32'd3);
      chk("t2_din3", 32'(obs_din[3]), 32'd9);
      chk("t2_addr3", 32'(obs_addr[3]), 32'h23);
    end

    // 3: address wrap, skipped empty entry, LOAD bubbles dropped
    wr(0, 1, 2, 16'hFFFF);
    wr(1, 1, 0, 16'h0010);
    wr(2, 1, 2, 16'h0040);
    do_run(3, 6, 16'h0A00, W, -1);
    chk("t3_nwrites", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("t3_addr0", 32'(obs_addr[0]), 32'hFFFF);
      chk("t3_addr1", 32'(obs_addr[1]), 32'h0000);
      chk("t3_addr2", 32'(obs_addr[2]), 32'h0040);
      chk("t3_addr3", 32'(obs_addr[3]), 32'h0041);
    end
    chk("t3_dropped", 32'(dropped), 32'd2);
    chk("t3_done", 32'(done_cnt), 32'd1);

    // 4: force_stop after 3 writes, with an ignored kick while busy
    wr(0, 1, 10, 0);
    do_run(1, 10, 16'h0300, 5, 3);
    chk("t4_nwrites", 32'(obs_addr.size()), 32'd3);
    chk("t4_done", 32'(done_cnt), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // 5: zero-length run
    do_run(0, 0, 0, W, -1);
    chk("t5_nwrites", 32'(obs_addr.size()), 32'd0);
    chk("t5_done", 32'(done_cnt), 32'd1);

    // 6: asynchronous reset in the middle of a capture
    wr(0, 1, 10, 0);
    kick = 1; ctrl_length = 1;
    @(posedge clk); #2;
    kick = 0;
    @(posedge clk); #2;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(16'h0700 + i);
      @(posedge clk); #2;
    end
    chk("t6_pre_busy", 32'(busy), 32'd1);
    chk("t6_pre_we", 32'(wave_we), 32'd1);
    rst_n = 0;
    #1;
    chk_reset_vals("t6_async");
    for (int i = 0; i < 16; i++) m_tab[i] = '0;
    @(posedge clk); #2;
    chk_reset_vals("t6_held");
    rst_n = 1; in_valid = 0; in_data = 0;
    wr(0, 1, 3, 16'h0100);
    do_run(1, 3, 16'h0500, W, -1);
    chk("t6_nwrites", 32'(obs_addr.size()), 32'd3);
    if (obs_addr.size() == 3) chk("t6_addr0", 32'(obs_addr[0]), 32'h0100);
    chk("t6_done", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
